data_mem_responder: RTL and testbench

//   Data-memory responder on the core's load/store port. It accepts one request at a

---
 rtl/data_mem_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Data-memory responder for the core's load/store port. It accepts one
//   request at a time over a valid/ready handshake and waits a fixed LATENCY.
//   It then commits a byte/half/word store, or captures a sign/zero-extended
//   load, and returns a single-cycle response pulse.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      wait cycles between accept and commit (0..15)
//   ADDR_BASE    byte address of word 0 (word-aligned)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept (registered, high only in IDLE)
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   req_funct3  RV32I width/sign code
//   rsp_valid   one-cycle completion pulse
//   rsp_rdata   formatted load data; 0 for stores and errors (held)
//   rsp_err     misaligned / illegal funct3 / out of range (held)
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic [1:0] {W_BYTE, W_HALF, W_WORD} width_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Request seen by the commit logic. With LATENCY==0 the commit happens on
  // the accept edge itself, before the request registers are loaded, so the
  // live inputs are used while in IDLE.
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_funct3;

  logic [31:0] off;
  logic [AW-1:0] idx;
  width_e      width;
  logic        is_unsigned, f3_err, align_err, range_err, err;
  logic        accept, commit;
  logic [31:0] rd_word, wr_word, wrep, ld_data;
  logic [3:0]  be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign accept = req_valid && ready_q;

  assign cur_we     = (state_q == IDLE) ? req_we     : we_q;
  assign cur_addr   = (state_q == IDLE) ? req_addr   : addr_q;
  assign cur_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;
  assign cur_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;

  // ---------------------------------------------------------------------------
  // Request decode: address range, width/sign, alignment.
  // ---------------------------------------------------------------------------
  assign off       = cur_addr - ADDR_BASE;
  assign idx       = off[AW+1:2];
  // Unsigned compare: an address below ADDR_BASE wraps to a huge offset.
  assign range_err = (off[31:AW+2] != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    width       = W_WORD;
    is_unsigned = 1'b0;
    f3_err      = 1'b0;
    unique case (cur_funct3)
      3'b000:  width = W_BYTE;
      3'b001:  width = W_HALF;
      3'b010:  width = W_WORD;
      3'b100: begin width = W_BYTE; is_unsigned = 1'b1; f3_err = cur_we; end
      3'b101: begin width = W_HALF; is_unsigned = 1'b1; f3_err = cur_we; end
      default: f3_err = 1'b1;
    endcase
  end

  // ADDR_BASE is word-aligned, so the offset's low bits equal the address's.
  assign align_err = ((width == W_HALF) && off[0]) ||
                     ((width == W_WORD) && (off[1:0] != 2'b00));
  assign err       = f3_err || align_err || range_err;

  // ---------------------------------------------------------------------------
  // Load formatting and store merge on the addressed word.
  // ---------------------------------------------------------------------------
  assign rd_word = mem[idx];
  assign ld_byte = rd_word[8*off[1:0] +: 8];
  assign ld_half = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    be      = 4'b1111;
    wrep    = cur_wdata;
    unique case (width)
      W_BYTE: begin
        ld_data = is_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        be      = 4'b0001 << off[1:0];
        wrep    = {4{cur_wdata[7:0]}};
      end
      W_HALF: begin
        ld_data = is_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        be      = off[1] ? 4'b1100 : 4'b0011;
        wrep    = {2{cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) wr_word[8*b +: 8] = wrep[8*b +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: IDLE -> BUSY -> RESP -> IDLE (BUSY skipped when LATENCY==0).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    unique case (state_q)
      IDLE: if (accept) begin
        we_d     = req_we;
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        funct3_d = req_funct3;
        cnt_d    = LAT4;
        state_d  = (LAT4 == 4'd0) ? RESP : BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The edge that enters RESP is the single point where memory is touched.
  assign commit = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    ready_d     = (state_d == IDLE);
    rsp_valid_d = commit;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (commit) begin
      rsp_err_d   = err;
      rsp_rdata_d = (err || cur_we) ? 32'h0 : ld_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      funct3_q    <= 3'b000;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: the memory array has no reset; it maps onto plain RAM.
  // A reset before the commit edge means no write ever happens.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !err) mem[idx] <= wr_word;
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Instance 0 uses LATENCY=2 and
//   instance 1 uses LATENCY=0. Both share the clock and reset.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int checks;
  int errors;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .ADDR_BASE(32'h0)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .ADDR_BASE(32'h0)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request on instance d and waits for its response. lat is the
  // cycle count from accept to rsp_valid (accept cycle's successor = 1);
  // a timeout leaves lat at 50 so the caller's latency check fails.
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_funct3[d] = f3;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready[0]); end
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid[0]); end
    checks++; if (rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata[0]); end
    checks++; if (rsp_err[0] !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", rsp_err[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic e; int lat;
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, F_W, rd, e, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency got %0d exp 3", lat); end
    checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL sw_rsp got %h/%b exp 0/0", rd, e); end
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL sw_pulse_width got %b exp 0", rsp_valid[0]); end
    do_req(0, 1'b0, 32'h10, 32'h0, F_W, rd, e, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lw_data got %h/%b exp deadbeef/0", rd, e); end
    checks++; if (rsp_rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold got %h exp deadbeef", rsp_rdata[0]); end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd; logic e; int lat;
    do_req(0, 1'b1, 32'h11, 32'hFFFF_FF7F, F_B, rd, e, lat);
    do_req(0, 1'b0, 32'h10, 32'h0, F_W, rd, e, lat);
    checks++; if (rd !== 32'hDEAD7FEF) begin errors++; $display("FAIL sb_merge got %h exp dead7fef", rd); end
    do_req(0, 1'b1, 32'h12, 32'hABCD_8001, F_H, rd, e, lat);
    do_req(0, 1'b0, 32'h10, 32'h0, F_W, rd, e, lat);
    checks++; if (rd !== 32'h80017FEF || e !== 1'b0) begin errors++; $display("FAIL sh_merge got %h/%b exp 80017fef/0", rd, e); end
    // Last word in range.
    do_req(0, 1'b1, 32'hFFC, 32'h1357_9BDF, F_W, rd, e, lat);
    do_req(0, 1'b0, 32'hFFC, 32'h0, F_W, rd, e, lat);
    checks++; if (rd !== 32'h13579BDF || e !== 1'b0) begin errors++; $display("FAIL top_word got %h/%b exp 13579bdf/0", rd, e); end
  endtask

  task automatic test_load_ext();
    logic [31:0] rd; logic e; int lat;
    logic [2:0]  f3  [6] = '{F_B, F_BU, F_H, F_HU, F_B, F_H};
    logic [31:0] ad  [6] = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h21, 32'h22};
    logic [31:0] exp [6] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h000080F0,
                             32'hFFFFFF80, 32'h00000000};
    do_req(0, 1'b1, 32'h20, 32'h0000_80F0, F_W, rd, e, lat);
    for (int i = 0; i < 6; i++) begin
      do_req(0, 1'b0, ad[i], 32'h0, f3[i], rd, e, lat);
      checks++;
      if (rd !== exp[i] || e !== 1'b0) begin
        errors++; $display("FAIL load_ext[%0d] got %h/%b exp %h/0", i, rd, e, exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    logic        we  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad  [6] = '{32'h22, 32'h21, 32'h20, 32'h1000, 32'h1000, 32'h20};
    logic [2:0]  f3  [6] = '{F_W, F_H, F_BAD, F_W, F_W, F_BU};
    // Prime the held response with nonzero data so err rdata=0 is visible.
    do_req(0, 1'b0, 32'h10, 32'h0, F_W, rd, e, lat);
    for (int i = 0; i < 6; i++) begin
      do_req(0, we[i], ad[i], 32'hA5A5_5A5A, f3[i], rd, e, lat);
      checks++;
      if (rd !== 32'h0 || e !== 1'b1 || lat !== 3) begin
        errors++; $display("FAIL err_case[%0d] got %h/%b lat %0d exp 0/1 lat 3", i, rd, e, lat);
      end
    end
    do_req(0, 1'b0, 32'h20, 32'h0, F_W, rd, e, lat);
    checks++; if (rd !== 32'h000080F0 || e !== 1'b0) begin errors++; $display("FAIL err_no_write got %h/%b exp 000080f0/0", rd, e); end
    do_req(0, 1'b0, 32'h0, 32'h0, F_W, rd, e, lat);
    checks++; if (rd === 32'hA5A5A5A5 || rd === 32'h5A5A5A5A || e !== 1'b0) begin errors++; $display("FAIL err_no_wrap_write got %h/%b exp not a5 pattern/0", rd, e); end
  endtask

  // req_valid held high across several requests on instance d.
  task automatic test_back_to_back(input int d, input int period, input logic [31:0] exp_rd);
    int pulses;
    pulses = 0;
    req_we[d] = 1'b0; req_addr[d] = 32'h10; req_wdata[d] = 32'h0; req_funct3[d] = F_W;
    req_valid[d] = 1'b1;
    for (int i = 0; i < 3 * period; i++) begin
      checks++;
      if (req_ready[d] !== ((i % period) == 0)) begin
        errors++; $display("FAIL b2b_ready[%0d] inst %0d got %b exp %b", i, d, req_ready[d], (i % period) == 0);
      end
      checks++;
      if (rsp_valid[d] !== ((i % period) == period - 1)) begin
        errors++; $display("FAIL b2b_rsp_valid[%0d] inst %0d got %b exp %b", i, d, rsp_valid[d], (i % period) == period - 1);
      end
      if (rsp_valid[d] === 1'b1) begin
        pulses++;
        checks++;
        if (rsp_rdata[d] !== exp_rd) begin errors++; $display("FAIL b2b_rdata inst %0d got %h exp %h", d, rsp_rdata[d], exp_rd); end
      end
      if (i == 3 * period - 1) req_valid[d] = 1'b0;
      @(negedge clk);
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses inst %0d got %0d exp 3", d, pulses); end
    @(negedge clk);
    checks++; if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin errors++; $display("FAIL b2b_extra_accept inst %0d got v%b r%b exp v0 r1", d, rsp_valid[d], req_ready[d]); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd; logic e; int lat;
    do_req(0, 1'b1, 32'h30, 32'h0BADF00D, F_W, rd, e, lat);
    @(negedge clk);
    req_we[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = 32'h12345678; req_funct3[0] = F_W;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got ready %b exp 0", req_ready[0]); end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_rsp_valid[%0d] got %b exp 0", i, rsp_valid[0]); end
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", req_ready[0]); end
    do_req(0, 1'b0, 32'h30, 32'h0, F_W, rd, e, lat);
    checks++; if (rd !== 32'h0BADF00D || e !== 1'b0) begin errors++; $display("FAIL rst_mid_no_write got %h/%b exp 0badf00d/0", rd, e); end
  endtask

  task automatic test_latency0();
    logic [31:0] rd; logic e; int lat;
    do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, F_W, rd, e, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL l0_sw_latency got %0d exp 1", lat); end
    do_req(1, 1'b0, 32'h10, 32'h0, F_W, rd, e, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL l0_lw_latency got %0d exp 1", lat); end
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL l0_lw_data got %h/%b exp deadbeef/0", rd, e); end
    do_req(1, 1'b1, 32'h13, 32'h0000_0011, F_B, rd, e, lat);
    do_req(1, 1'b0, 32'h12, 32'h0, F_H, rd, e, lat);
    checks++; if (rd !== 32'h000011AD || e !== 1'b0) begin errors++; $display("FAIL l0_sb_lh got %h/%b exp 000011ad/0", rd, e); end
    do_req(1, 1'b0, 32'h11, 32'h0, F_W, rd, e, lat);
    checks++; if (rd !== 32'h0 || e !== 1'b1 || lat !== 1) begin errors++; $display("FAIL l0_err got %h/%b lat %0d exp 0/1 lat 1", rd, e, lat); end
    test_back_to_back(1, 2, 32'h11ADBEEF);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_funct3[d] = 3'b000;
    end
    #2;
    test_reset();
    test_word_rw();
    test_partial_store();
    test_load_ext();
    test_errors();
    test_back_to_back(0, 4, 32'h80017FEF);
    test_reset_mid_op();
    test_latency0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a wait ever escapes its bound.
  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
